// File: rtl/winograd_out_packer.sv
// Packs 2x2 Winograd output tiles (4 words each) four to a 512-bit line, with a
// zero-padded final line tagged out_last. Build with WINO_OUT_RELU_EN to ReLU words on accept.

module winograd_out_packer_word #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);
`ifdef WINO_OUT_RELU_EN
    // Sign bit set covers float negatives, -0.0 and two's-complement negatives alike.
    assign dout = din[DATA_WIDTH-1] ? '0 : din;
`else
    assign dout = din;
`endif
endmodule

module winograd_out_packer #(
    parameter int DATA_WIDTH     = 32,
    parameter int TILES_PER_LINE = 512 / (4 * DATA_WIDTH),
    parameter int COUNT_WIDTH    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] ctx_length,
    input  logic [511:0]           in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [511:0]           out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] tile_count
);
    localparam int WORDS  = 4;
    localparam int TILE_W = WORDS * DATA_WIDTH;
    localparam int SLOT_W = (TILES_PER_LINE > 1) ? $clog2(TILES_PER_LINE) : 1;

    typedef enum logic [1:0] {IDLE, PACK, DRAIN} state_t;
    state_t state, state_d;

    logic [WORDS-1:0][DATA_WIDTH-1:0]         tile_raw, tile_w;
    logic [TILES_PER_LINE-1:0][TILE_W-1:0]    asm_buf, line_next, out_line;
    logic [SLOT_W-1:0]                        slot;
    logic [COUNT_WIDTH-1:0]                   remaining;
    logic                                     line_closes, accept, out_hs, last_tile;
    logic                                     unused_in;

    // y00/y01 sit in the low row of the PE line, y10/y11 one 128-bit row up.
    assign tile_raw[0] = in_data[0*DATA_WIDTH +: DATA_WIDTH];
    assign tile_raw[1] = in_data[1*DATA_WIDTH +: DATA_WIDTH];
    assign tile_raw[2] = in_data[4*DATA_WIDTH +: DATA_WIDTH];
    assign tile_raw[3] = in_data[5*DATA_WIDTH +: DATA_WIDTH];
    assign unused_in   = ^{in_data[511:6*DATA_WIDTH], in_data[4*DATA_WIDTH-1:2*DATA_WIDTH]};

    for (genvar g = 0; g < WORDS; g++) begin : g_word
        winograd_out_packer_word #(.DATA_WIDTH(DATA_WIDTH)) u_word (
            .din  (tile_raw[g]),
            .dout (tile_w[g])
        );
    end

    assign last_tile   = (remaining == COUNT_WIDTH'(1));
    assign line_closes = (slot == SLOT_W'(TILES_PER_LINE - 1)) || last_tile;
    assign in_ready    = (state == PACK) && (!line_closes || !out_valid || out_ready);
    assign accept      = in_valid && in_ready;
    assign out_hs      = out_valid && out_ready;
    assign out_data    = out_line;

    // Buffer slots at or above `slot` are always zero, so the current tile
    // dropped into its slot gives the zero-padded line directly.
    always_comb begin
        line_next       = asm_buf;
        line_next[slot] = tile_w;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (start && ctx_length != '0) state_d = PACK;
            PACK:    if (accept && last_tile)       state_d = DRAIN;
            DRAIN:   if (out_hs)                    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            asm_buf    <= '0;
            out_line   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            done       <= 1'b0;
            slot       <= '0;
            remaining  <= '0;
            tile_count <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && start) begin
                if (ctx_length != '0) begin
                    remaining  <= ctx_length;
                    slot       <= '0;
                    tile_count <= '0;
                end else begin
                    done <= 1'b1;
                end
            end
            if (state == DRAIN && out_hs) done <= 1'b1;
            if (out_hs) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            // A reload here overrides the drain above: back-to-back lines, no bubble.
            if (accept) begin
                remaining  <= remaining - COUNT_WIDTH'(1);
                tile_count <= tile_count + COUNT_WIDTH'(1);
                if (line_closes) begin
                    out_line  <= line_next;
                    out_valid <= 1'b1;
                    out_last  <= last_tile;
                    slot      <= '0;
                    asm_buf   <= '0;
                end else begin
                    asm_buf <= line_next;
                    slot    <= slot + SLOT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_winograd_out_packer.sv
// Self-checking bench for winograd_out_packer: table of jobs plus directed corner
// cases, randomized handshakes checked against a tile-queue reference model.

module tb_winograd_out_packer;
    logic         clk = 1'b0, reset = 1'b0, start = 1'b0;
    logic [31:0]  ctx_length = '0;
    logic [511:0] in_data = '0;
    logic         in_valid = 1'b0, out_ready = 1'b0;
    logic         in_ready, out_valid, out_last, done;
    logic [511:0] out_data;
    logic [31:0]  tile_count;

    winograd_out_packer dut (
        .clk(clk), .reset(reset), .start(start), .ctx_length(ctx_length),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .done(done), .tile_count(tile_count)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    logic [511:0] tiles [64];
    logic [511:0] last_line;

    typedef struct {
        int len; int in_pct; int out_pct; int stall;   // inputs
        int exp_lines;                                  // expected
    } job_t;
    job_t tbl [5];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] relu(input logic [31:0] w);
`ifdef WINO_OUT_RELU_EN
        return w[31] ? 32'h0 : w;
`else
        return w;
`endif
    endfunction

    function automatic logic [511:0] rand_line();
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    // Reference: line j holds tiles 4j..4j+3 of the job, zeros past the end.
    function automatic logic [511:0] exp_line(input int j, input int len);
        logic [511:0] l;
        logic [511:0] t;
        l = '0;
        for (int k = 0; k < 4; k++) begin
            if (4*j + k < len) begin
                t = tiles[4*j + k];
                l[128*k +: 128] = {relu(t[191:160]), relu(t[159:128]), relu(t[63:32]), relu(t[31:0])};
            end
        end
        return l;
    endfunction

    task automatic run_job(input int len, input int in_pct, input int out_pct,
                           input int stall, input int exp_lines, input bit gen);
        int ptr, lines, nl;
        bit expect_ov, held, last_hs, acc, hs, closes, exp_rdy, held_last;
        logic [511:0] held_data;
        ptr = 0; lines = 0; nl = (len + 3) / 4;
        expect_ov = 0; held = 0; last_hs = 0; held_last = 0; held_data = '0;
        if (gen) for (int i = 0; i < len; i++) tiles[i] = rand_line();
        @(posedge clk); #1;
        start = 1'b1; ctx_length = len; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        for (int cyc = 0; cyc < 2000; cyc++) begin
            #1;
            // stray starts mid-job must be ignored
            start      = !last_hs && ($urandom_range(0, 7) == 0);
            ctx_length = $urandom_range(1, 50);
            in_valid   = (ptr < len) && ($urandom_range(1, 100) <= in_pct);
            in_data    = (ptr < len) ? tiles[ptr] : rand_line();
            out_ready  = (cyc >= stall) && ($urandom_range(1, 100) <= out_pct);
            #1;
            if (expect_ov) chk("latency_out_valid", out_valid, 1);
            if (held) begin
                chk("hold_data", out_data, held_data);
                chk("hold_last", out_last, held_last);
            end
            chk("done", done, last_hs);
            if (last_hs) begin
                chk("tile_count", tile_count, len);
                chk("line_count", lines, exp_lines);
                chk("in_ready_idle", in_ready, 0);
                return;
            end
            closes  = (ptr % 4 == 3) || (ptr == len - 1);
            exp_rdy = (ptr < len) && !(closes && out_valid && !out_ready);
            chk("in_ready", in_ready, exp_rdy);
            acc = in_valid && in_ready;
            hs  = out_valid && out_ready;
            expect_ov = acc && closes;
            if (acc) ptr++;
            if (hs) begin
                chk("line_data", out_data, exp_line(lines, len));
                chk("line_last", out_last, lines == nl - 1);
                last_line = out_data;
                lines++;
                if (lines == nl) last_hs = 1;
            end
            held = out_valid && !out_ready;
            held_data = out_data;
            held_last = out_last;
            @(posedge clk);
        end
        vectors++; miscompares++;
        $display("FAIL job_timeout: len %0d got %0d lines expected %0d", len, lines, nl);
        start = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_tile_count"}, tile_count, 0);
    endtask

    initial begin
        int n, len;
        logic [127:0] relu_exp;
        tbl[0] = '{len: 4,  in_pct: 100, out_pct: 100, stall: 0, exp_lines: 1};
        tbl[1] = '{len: 6,  in_pct: 100, out_pct: 100, stall: 0, exp_lines: 2};
        tbl[2] = '{len: 8,  in_pct: 100, out_pct: 100, stall: 9, exp_lines: 2};
        tbl[3] = '{len: 8,  in_pct: 100, out_pct: 100, stall: 5, exp_lines: 2};
        tbl[4] = '{len: 13, in_pct: 70,  out_pct: 60,  stall: 3, exp_lines: 4};

        repeat (2) @(posedge clk);
        #1 chk_all_zero("reset");
        reset = 1'b1;

        foreach (tbl[i]) run_job(tbl[i].len, tbl[i].in_pct, tbl[i].out_pct, tbl[i].stall, tbl[i].exp_lines, 1);

        // zero-length job: done only
        @(posedge clk); #1;
        start = 1'b1; ctx_length = 0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        chk("zero_len_done", done, 1);
        chk("zero_len_out_valid", out_valid, 0);
        chk("zero_len_in_ready", in_ready, 0);
        @(posedge clk); #2;
        chk("zero_len_done_pulse", done, 0);
        chk("zero_len_out_valid2", out_valid, 0);
        in_valid = 1'b0;

        // reset mid-job after 5 accepts
        @(posedge clk); #1;
        start = 1'b1; ctx_length = 10; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; n = 0;
        for (int c = 0; c < 20 && n < 5; c++) begin
            in_data = rand_line();
            #1 if (in_ready) n++;
            @(posedge clk); #1;
        end
        chk("midjob_accepts", n, 5);
        reset = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        chk_all_zero("midjob_reset");
        reset = 1'b1;
        run_job(1, 100, 100, 0, 1, 1);
        chk("after_reset_slot0", last_line[511:128], 0);

        // sign-bit words
        tiles[0] = rand_line();
        tiles[0][31:0]    = 32'hBF800000;
        tiles[0][63:32]   = 32'h3F800000;
        tiles[0][159:128] = 32'h80000000;
        tiles[0][191:160] = 32'hFFFFFFFF;
        run_job(1, 100, 100, 0, 1, 0);
`ifdef WINO_OUT_RELU_EN
        relu_exp = {32'h0, 32'h0, 32'h3F800000, 32'h0};
`else
        relu_exp = {32'hFFFFFFFF, 32'h80000000, 32'h3F800000, 32'hBF800000};
`endif
        chk("relu_tile", last_line[127:0], relu_exp);

        for (int j = 0; j < 8; j++) begin
            len = $urandom_range(1, 40);
            run_job(len, $urandom_range(40, 100), $urandom_range(30, 100),
                    $urandom_range(0, 6), (len + 3) / 4, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/winograd_out_packer.md
Name: winograd_out_packer

Overview:
- Downstream of the Winograd F(2x2,3x3) stage; consumes its 512-bit result lines, each carrying one 2x2 output tile (4 x 32-bit words).
- Packs 4 tiles per 512-bit output line, cutting output-FIFO and host write bandwidth by 4x.
- Counts tiles against a host-supplied length, emits a zero-padded final partial line tagged last, and pulses done.
- Uses valid/ready on both sides, so it can sit between the PE result path and the output FIFO.

Parameters:
- DATA_WIDTH, 32, width of one result word; only 32 is supported.
- TILES_PER_LINE, 4, tiles per output line; fixed at 512/(4*DATA_WIDTH).
- COUNT_WIDTH, 32, width of the tile length and counters.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; latches ctx_length and begins a job
- ctx_length  in  COUNT_WIDTH  number of input tiles in the job
- in_data  in  512  PE result line; y00=[31:0], y01=[63:32], y10=[159:128], y11=[191:160]; all other bits ignored
- in_valid  in  1  in_data valid
- in_ready  out  1  packer accepts in_data this cycle
- out_data  out  512  packed line; tile k at [128k+127:128k], words y00,y01,y10,y11 from low to high
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data
- out_last  out  1  qualifies out_data as the final line of the job
- done  out  1  one-cycle pulse at job completion
- tile_count  out  COUNT_WIDTH  tiles accepted in the current/last job

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; in_ready, out_valid, out_last, done = 0; out_data, assembly buffer, slot, remaining, tile_count = 0. Reset mid-job discards all data; no partial line is emitted.
- FSM states: IDLE, PACK, DRAIN.
- IDLE:
  - start && ctx_length!=0: remaining<=ctx_length, slot<=0, tile_count<=0, go PACK.
  - start && ctx_length==0: done=1 next cycle, stay IDLE, no output line.
  - start outside IDLE is ignored.
- Accept = in_valid && in_ready.
- line_closes = (slot==3) || (remaining==1).
- in_ready = (state==PACK) && (!line_closes || !out_valid || out_ready). Combinational; in_ready must not depend on in_valid.
- On accept:
  - Tile words are written into assembly slot `slot`.
  - remaining decrements; tile_count increments.
  - If !line_closes: slot increments.
  - If line_closes: the assembled line (this tile included) loads out_data, with unfilled slots zero. out_valid<=1; out_last<=(remaining==1); slot<=0; buffer cleared.
  - If remaining==1: go DRAIN.
- Latency: the closing tile accepted at cycle t gives out_valid at t+1. Sustained throughput is 1 tile/cycle with out_ready held high.
- Output register:
  - Holds out_data, out_valid and out_last stable until out_valid && out_ready.
  - Clears out_valid on handshake unless reloaded in the same cycle.
  - Simultaneous drain and reload is allowed and is a new line, not a hold.
- DRAIN: in_ready=0. On handshake of the last line: done=1 for one cycle, go IDLE.
- tile_count holds its value in IDLE until the next start.
- Arithmetic: counters are unsigned and wrap modulo 2^COUNT_WIDTH; ctx_length above 2^32-1 is not supported.

Optional Feature:
- Macro WINO_OUT_RELU_EN.
- Defined: each word is ReLU'd on accept. A word with bit31==1 is stored as 32'h0, which covers IEEE-754 negatives, -0.0 and two's-complement negatives. Zero padding is unaffected.
- Undefined: words pass bit-exact. Latency and handshakes are identical either way.

Test Plan:
- ctx_length=4, 4 back-to-back tiles with words {k*4+0..3}, out_ready=1:
  - in_ready high all 4 cycles.
  - One line 1 cycle after the 4th accept, tile k at [128k+127:128k], out_last=1.
  - done one cycle after the handshake; tile_count=4.
- ctx_length=6, continuous input, out_ready=1: line 1 with out_last=0; line 2 with tiles 4,5 in slots 0-1, [511:256]=0, out_last=1; done after line 2.
- ctx_length=8, out_ready=0 for 5 cycles:
  - First line is held stable.
  - in_ready drops on the 8th tile (slot 3 with out_valid && !out_ready).
  - Resumes when out_ready rises; no tile lost or duplicated, and line order is preserved.
- start with ctx_length=0: done pulses 1 cycle later, out_valid never asserts, in_ready stays 0.
- ctx_length=10, reset=0 after 5 accepts:
  - Next cycle all outputs are 0 and state is IDLE.
  - A new start with ctx_length=1 yields one line with the tile in slot 0, rest 0, out_last=1.
- WINO_OUT_RELU_EN defined, tile words {32'hBF800000, 32'h3F800000, 32'h80000000, 32'hFFFFFFFF}, ctx_length=1: out_data[127:0] = {0, 0, 3F800000, 0} from high to low. Undefined: out_data[127:0] unchanged.
